// File: rtl/alu_ctrl_md_if.sv
// alu_ctrl_md_if: instruction/operand bus and results of the ALU control and multiply/divide unit.
interface alu_ctrl_md_if #(parameter int WIDTH = 32);
    logic valid;
    logic [1:0] alu_op;
    logic [5:0] func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0] alu_ctl;
    logic [1:0] res_sel;
    logic stall;
    logic md_busy;
    logic md_done;
    logic dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output valid, alu_op, func, a, b,
                    input alu_ctl, res_sel, stall, md_busy, md_done, dbz, hi, lo);
    modport slave (input valid, alu_op, func, a, b,
                   output alu_ctl, res_sel, stall, md_busy, md_done, dbz, hi, lo);
endinterface

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: ALU control decode plus iterative shift-add multiplier / restoring divider with HI/LO.
// Define ALU_MD_SIGNED_EN for signed mult/div (func 24/26); otherwise all mult/div are unsigned.
module alu_ctrl_md #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst_n,
    alu_ctrl_md_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] r, q, d, nr, nq, ua, ub;
    logic [WIDTH:0] sum, sh, diff;
    logic [2*WIDTH-1:0] res;
    logic [2:0] fd;
    logic rd, is_md, is_mul, can_go, md_start;
`ifdef ALU_MD_SIGNED_EN
    logic sgn, neg_p, neg_r;
`endif
    always_comb begin
        fd = (bus.func == 6'd32 || bus.func == 6'd33) ? 3'b000 :
             (bus.func == 6'd34 || bus.func == 6'd35) ? 3'b011 :
             bus.func == 6'd36 ? 3'b001 :
             bus.func == 6'd37 ? 3'b010 :
             bus.func == 6'd38 ? 3'b110 :
             bus.func == 6'd39 ? 3'b101 :
             (bus.func == 6'd42 || bus.func == 6'd43) ? 3'b100 : 3'b000;
        bus.alu_ctl = bus.alu_op == 2'd0 ? 3'b000 : bus.alu_op == 2'd1 ? 3'b011 :
                      bus.alu_op == 2'd3 ? 3'b010 : fd;
        bus.res_sel = bus.alu_op == 2'd2 && bus.func == 6'd16 ? 2'b01 :
                      bus.alu_op == 2'd2 && bus.func == 6'd18 ? 2'b10 : 2'b00;
        rd = bus.valid && bus.alu_op == 2'd2;
        is_md = bus.func[5:2] == 4'b0110;
        is_mul = ~bus.func[1];
        can_go = state == IDLE || state == DONE;
        md_start = rd && is_md && can_go;
        bus.stall = rd && bus.md_busy && (is_md || bus.func[5:2] == 4'b0100);
`ifdef ALU_MD_SIGNED_EN
        sgn = ~bus.func[0];
        ua = sgn && bus.a[WIDTH-1] ? -bus.a : bus.a;
        ub = sgn && bus.b[WIDTH-1] ? -bus.b : bus.b;
`else
        ua = bus.a;
        ub = bus.b;
`endif
        // one iteration of either algorithm; r/q carry the high/low halves
        sum = {1'b0, r} + (q[0] ? {1'b0, d} : '0);
        sh = {r, q[WIDTH-1]};
        diff = sh - {1'b0, d};
        nr = state == MUL ? sum[WIDTH:1] : (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]);
        nq = state == MUL ? {sum[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~diff[WIDTH]};
`ifdef ALU_MD_SIGNED_EN
        res = state == MUL ? (neg_p ? -{nr, nq} : {nr, nq}) : {neg_r ? -nr : nr, neg_p ? -nq : nq};
`else
        res = {nr, nq};
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            r <= '0;
            q <= '0;
            d <= '0;
            bus.hi <= '0;
            bus.lo <= '0;
            bus.dbz <= 1'b0;
            bus.md_busy <= 1'b0;
            bus.md_done <= 1'b0;
`ifdef ALU_MD_SIGNED_EN
            neg_p <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else if (state == MUL || state == DIV) begin
            cnt <= cnt + 1'b1;
            r <= nr;
            q <= nq;
            if (cnt == CW'(WIDTH - 1)) begin
                state <= DONE;
                bus.md_busy <= 1'b0;
                bus.md_done <= 1'b1;
                {bus.hi, bus.lo} <= res;
            end
        end else begin
            state <= IDLE;
            bus.md_done <= 1'b0;
            if (md_start && !is_mul && bus.b == '0) begin
                state <= DONE;
                bus.md_done <= 1'b1;
                bus.hi <= bus.a;
                bus.lo <= '1;
                bus.dbz <= 1'b1;
            end else if (md_start) begin
                state <= is_mul ? MUL : DIV;
                bus.md_busy <= 1'b1;
                cnt <= '0;
                r <= '0;
                q <= is_mul ? ub : ua;
                d <= is_mul ? ua : ub;
                if (!is_mul) bus.dbz <= 1'b0;
`ifdef ALU_MD_SIGNED_EN
                neg_p <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r <= sgn && bus.a[WIDTH-1];
`endif
            end else if (rd && bus.func == 6'd17 && can_go) begin
                bus.hi <= bus.a;
            end else if (rd && bus.func == 6'd19 && can_go) begin
                bus.lo <= bus.a;
            end
        end
    end
endmodule

// File: doc/alu_ctrl_md.md
ALU_CTRL_MD -- requirements
Module: alu_ctrl_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of operands and HI/LO (even, ≥8).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: valid  in  1  instruction present this cycle; alu_op  in  2  main-decoder class; func  in  6  R-type funct field.
REQ-005 SHALL have ports: a  in  WIDTH  rs operand; b  in  WIDTH  rt operand.
REQ-006 SHALL have ports: alu_ctl  out  3  ALU operation; res_sel  out  2  writeback source (00 ALU, 01 HI, 10 LO).
REQ-007 SHALL have ports: stall  out  1  hold pipeline; md_busy  out  1  iterative unit active; md_done  out  1  one-cycle completion pulse; dbz  out  1  last divide had zero divisor; hi  out  WIDTH; lo  out  WIDTH.

Function
REQ-008 alu_ctl SHALL be combinational: alu_op 0→000 add; 1→011 sub; 3→010 or; 2→decode func.
REQ-009 func decode: 32/33→000 add; 34/35→011 sub; 36→001 and; 37→010 or; 38→110 xor; 39→101 nor; 42/43→100 slt; other→000.
REQ-010 res_sel SHALL be 01 for alu_op 2, func 16 (mfhi); 10 for func 18 (mflo); else 00.
REQ-011 Multiply/divide ops (alu_op 2): func 24 mult, 25 multu, 26 div, 27 divu; mthi 17, mtlo 19.
REQ-012 FSM states IDLE, MUL, DIV, DONE; reset state IDLE; md_busy=1 exactly in MUL and DIV.
REQ-013 In IDLE with valid and mult/multu at edge N: capture a,b, enter MUL; shift-add one bit per cycle for WIDTH cycles (N+1..N+WIDTH); {hi,lo} written at end of N+WIDTH; DONE during N+WIDTH+1.
REQ-014 div/divu identical timing via restoring division in DIV: lo=quotient, hi=remainder.
REQ-015 Divisor zero: skip DIV, enter DONE at N+1; hi=a, lo=all ones, dbz=1; any non-zero divide clears dbz.
REQ-016 md_done SHALL be 1 only in DONE; DONE→IDLE unconditionally next cycle; a new op may start in DONE cycle (DONE→MUL/DIV directly).
REQ-017 mthi/mtlo in IDLE or DONE SHALL write hi/lo from a at that edge, no state change.
REQ-018 stall SHALL be 1 when valid and md_busy and func ∈ {16,17,18,19,24,25,26,27} with alu_op 2; else 0; stalled ops SHALL NOT start or write.
REQ-019 Iteration counter width clog2(WIDTH)+1; no wrap beyond WIDTH iterations.
REQ-020 valid=0 or alu_op≠2 SHALL never start an op or write hi/lo.

Reset
REQ-021 rst_n low, at any time incl. mid-operation: state IDLE, hi=0, lo=0, dbz=0, md_done=0, md_busy=0, counter and operand registers 0; partial results discarded.
REQ-022 First op SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-023 Macro ALU_MD_SIGNED_EN defined: mult/div signed two's-complement (operate on magnitudes, correct signs; remainder sign = dividend sign; MIN/−1 gives lo=MIN, hi=0), same latency.
REQ-024 Macro absent: func 24/26 SHALL behave exactly as 25/27 (unsigned); no sign-correction logic present.

Verification (WIDTH=32)
REQ-025 alu_op=2 func=42 → alu_ctl=100; func=39 → 101; alu_op=1 → 011; alu_op=2 func=16 → res_sel=01.
REQ-026 multu a=0xFFFFFFFF b=2 at edge N → md_busy cycles N+1..N+32, md_done at N+33, hi=0x00000001, lo=0xFFFFFFFE.
REQ-027 With ALU_MD_SIGNED_EN: mult a=−3 b=5 → hi=0xFFFFFFFF lo=0xFFFFFFF1; div a=−7 b=2 → lo=0xFFFFFFFD hi=0xFFFFFFFF; without macro div 0xFFFFFFF9/2 → lo=0x7FFFFFFC hi=1.
REQ-028 divu a=5 b=0 → md_done at N+1, dbz=1, hi=5, lo=0xFFFFFFFF; then divu 100/7 → lo=14, hi=2, dbz=0.
REQ-029 mflo issued at N+5 during multiply → stall=1 until N+32, 0 in DONE; mthi a=0x1234 while busy → hi unchanged.
REQ-030 rst_n low at N+10 of multiply → md_busy=0, hi=lo=0, no md_done pulse; fresh multu 3×4 afterwards → lo=12.
